// File: rtl/calc_stack_gen.sv
// Calculator operand stack: TOS in a register, lower entries in a single-port sync-read RAM.
// Optional high-water-mark output enabled by defining CALC_STACK_HWM_EN.
module calc_stack_gen #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 512,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] in_num,
  output logic             ready,
  output logic [AW:0]      size,
  output logic [WIDTH-1:0] top,
  output logic             error,
  output logic             empty,
  output logic             full
`ifdef CALC_STACK_HWM_EN
  ,
  output logic [AW:0]      hwm
`endif
);

  localparam logic [2:0] OpPush    = 3'd1;
  localparam logic [2:0] OpPop     = 3'd2;
  localparam logic [2:0] OpReplace = 3'd3;
  localparam logic [2:0] OpSwap    = 3'd4;
  localparam logic [2:0] OpDup     = 3'd5;
  localparam logic [2:0] OpClear   = 3'd6;

  localparam logic [AW:0] SizeOne = (AW+1)'(1);
  localparam logic [AW:0] SizeTwo = (AW+1)'(2);
  localparam logic [AW:0] SizeMax = (AW+1)'(DEPTH);

  typedef enum logic [0:0] {StIdle, StRd} state_e;

  state_e           state_q, state_d;
  logic [AW:0]      size_q, size_d;
  logic [WIDTH-1:0] top_q, top_d;
  logic             error_q, error_d;
  logic             swap_q, swap_d;

  logic [WIDTH-1:0] mem [DEPTH-1];
  logic [WIDTH-1:0] ram_rdata;
  logic [AW-1:0]    ram_addr;
  logic [WIDTH-1:0] ram_wdata;
  logic             ram_we;
  logic [AW-1:0]    addr_m1, addr_m2;

  assign addr_m1 = AW'(size_q - SizeOne);
  assign addr_m2 = AW'(size_q - SizeTwo);

  assign empty = (size_q == '0);
  assign full  = (size_q == SizeMax);
  assign ready = (state_q == StIdle);
  assign size  = size_q;
  assign top   = top_q;
  assign error = error_q;

  // Read-before-write: rdata always reflects the pre-write contents.
  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  always_comb begin
    state_d   = state_q;
    size_d    = size_q;
    top_d     = top_q;
    error_d   = error_q;
    swap_d    = swap_q;
    ram_we    = 1'b0;
    ram_addr  = addr_m2;
    ram_wdata = top_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          case (cmd_op)
            OpPush: begin
              if (full) begin
                error_d = 1'b1;
              end else begin
                error_d = 1'b0;
                top_d   = in_num;
                size_d  = size_q + SizeOne;
                if (!empty) begin
                  ram_we   = 1'b1;
                  ram_addr = addr_m1;
                end
              end
            end
            OpPop: begin
              if (empty) begin
                error_d = 1'b1;
              end else begin
                error_d = 1'b0;
                size_d  = size_q - SizeOne;
                if (size_q == SizeOne) begin
                  top_d = '0;
                end else begin
                  swap_d  = 1'b0;
                  state_d = StRd;
                end
              end
            end
            OpReplace: begin
              if (empty) begin
                error_d = 1'b1;
              end else begin
                error_d = 1'b0;
                top_d   = in_num;
              end
            end
            OpSwap: begin
              if (size_q < SizeTwo) begin
                error_d = 1'b1;
              end else begin
                error_d = 1'b0;
                swap_d  = 1'b1;
                state_d = StRd;
              end
            end
            OpDup: begin
              if (empty || full) begin
                error_d = 1'b1;
              end else begin
                error_d  = 1'b0;
                size_d   = size_q + SizeOne;
                ram_we   = 1'b1;
                ram_addr = addr_m1;
              end
            end
            OpClear: begin
              error_d = 1'b0;
              size_d  = '0;
              top_d   = '0;
            end
            default: ;
          endcase
        end
      end
      StRd: begin
        top_d   = ram_rdata;
        // Swap leaves size unchanged, so addr_m2 still names the slot just read.
        ram_we  = swap_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (!reset) ram_we = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      size_q  <= '0;
      top_q   <= '0;
      error_q <= 1'b0;
      swap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      size_q  <= size_d;
      top_q   <= top_d;
      error_q <= error_d;
      swap_q  <= swap_d;
    end
  end

`ifdef CALC_STACK_HWM_EN
  logic [AW:0] hwm_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hwm_q <= '0;
    end else if (size_d > hwm_q) begin
      hwm_q <= size_d;
    end
  end

  assign hwm = hwm_q;
`endif

endmodule

// File: tb/tb_calc_stack_gen.sv
// Scoreboard bench for calc_stack_gen (DEPTH=4); expectations come from a queue-based stack model.
module tb_calc_stack_gen;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 2;

  localparam logic [2:0] OpNop = 3'd0, OpPush = 3'd1, OpPop = 3'd2, OpReplace = 3'd3;
  localparam logic [2:0] OpSwap = 3'd4, OpDup = 3'd5, OpClear = 3'd6, OpRsvd = 3'd7;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             cmd_valid = 1'b0;
  logic [2:0]       cmd_op = '0;
  logic [WIDTH-1:0] in_num = '0;
  logic             ready, error, empty, full;
  logic [AW:0]      size;
  logic [WIDTH-1:0] top;
`ifdef CALC_STACK_HWM_EN
  logic [AW:0]      hwm;
`endif

  calc_stack_gen #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cmd_valid(cmd_valid),
    .cmd_op   (cmd_op),
    .in_num   (in_num),
    .ready    (ready),
    .size     (size),
    .top      (top),
    .error    (error),
    .empty    (empty),
    .full     (full)
`ifdef CALC_STACK_HWM_EN
    ,
    .hwm      (hwm)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          sz;
    logic [31:0] tp;
    logic        err;
    int          lat;
    int          hw;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] stk[$];
  logic        m_err;
  int          m_hwm;
  int          n_total = 0;
  int          n_bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model(input logic [2:0] op, input logic [31:0] num, input string tag,
                       output exp_t e);
    int n;
    logic [31:0] t;
    n     = stk.size();
    e.lat = 1;
    case (op)
      OpPush:    if (n == DEPTH) m_err = 1'b1; else begin stk.push_back(num); m_err = 1'b0; end
      OpPop: begin
        if (n == 0) m_err = 1'b1;
        else begin
          void'(stk.pop_back());
          m_err = 1'b0;
          if (n > 1) e.lat = 2;
        end
      end
      OpReplace: if (n == 0) m_err = 1'b1; else begin stk[n-1] = num; m_err = 1'b0; end
      OpSwap: begin
        if (n < 2) m_err = 1'b1;
        else begin
          t = stk[n-1]; stk[n-1] = stk[n-2]; stk[n-2] = t;
          m_err = 1'b0;
          e.lat = 2;
        end
      end
      OpDup: begin
        if (n == 0 || n == DEPTH) m_err = 1'b1;
        else begin t = stk[n-1]; stk.push_back(t); m_err = 1'b0; end
      end
      OpClear: begin stk.delete(); m_err = 1'b0; end
      default: ;
    endcase
    if (stk.size() > m_hwm) m_hwm = stk.size();
    e.tag = tag;
    e.sz  = stk.size();
    e.tp  = (stk.size() == 0) ? 32'd0 : stk[stk.size()-1];
    e.err = m_err;
    e.hw  = m_hwm;
  endtask

  task automatic check_state(input exp_t e);
    check({e.tag, " size"}, 64'(size), 64'(e.sz));
    check({e.tag, " top"}, 64'(top), 64'(e.tp));
    check({e.tag, " error"}, 64'(error), 64'(e.err));
    check({e.tag, " empty"}, 64'(empty), 64'(e.sz == 0));
    check({e.tag, " full"}, 64'(full), 64'(e.sz == DEPTH));
`ifdef CALC_STACK_HWM_EN
    check({e.tag, " hwm"}, 64'(hwm), 64'(e.hw));
`endif
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] num, input string tag);
    exp_t e;
    int   lat;
    model(op, num, tag, e);
    sb.push_back(e);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; in_num = num;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0; cmd_op = OpNop;
    lat = 1;
    while (!ready && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    e = sb.pop_front();
    check({e.tag, " ready"}, 64'(ready), 64'd1);
    check({e.tag, " latency"}, 64'(lat), 64'(e.lat));
    check_state(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; cmd_valid = 1'b0;
    stk.delete(); m_err = 1'b0; m_hwm = 0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    exp_t e;
    m_err = 1'b0; m_hwm = 0;
    do_reset();
    check("reset ready", 64'(ready), 64'd1);
    e.tag = "reset"; e.sz = 0; e.tp = 0; e.err = 0; e.lat = 1; e.hw = 0;
    check_state(e);

    issue(OpPush, 32'd5, "push5");
    issue(OpPush, 32'd7, "push7");
    issue(OpPop, 32'd0, "pop->5");

    issue(OpClear, 32'd0, "clear1");
    issue(OpPop, 32'd0, "pop empty");
    issue(OpRsvd, 32'd0, "rsvd keeps err");
    issue(OpNop, 32'd0, "nop keeps err");
    issue(OpPush, 32'd3, "push3");

    issue(OpClear, 32'd0, "clear2");
    issue(OpPush, 32'd1, "push1");
    issue(OpPush, 32'd2, "push2");
    issue(OpSwap, 32'd0, "swap");
    issue(OpPop, 32'd0, "pop after swap");
    issue(OpSwap, 32'd0, "swap size1");

    issue(OpClear, 32'd0, "clear3");
    for (int i = 1; i <= 4; i++) issue(OpPush, 32'(10 * i), $sformatf("fill%0d", i));
    issue(OpPush, 32'd50, "push full");
    issue(OpDup, 32'd0, "dup full");
    issue(OpReplace, 32'd44, "replace full");
    for (int i = 0; i < 4; i++) issue(OpPop, 32'd0, $sformatf("drain%0d", i));
    issue(OpReplace, 32'd1, "replace empty");
    issue(OpDup, 32'd0, "dup empty");

    do_reset();
    issue(OpPush, 32'd9, "push9");
    issue(OpDup, 32'd0, "dup");
    issue(OpReplace, 32'd4, "replace4");
    issue(OpPop, 32'd0, "pop->9");
    issue(OpClear, 32'd0, "clear4");

    // POP with a PUSH held on cmd_valid while busy: the PUSH must be dropped.
    issue(OpPush, 32'd1, "p1");
    issue(OpPush, 32'd2, "p2");
    issue(OpPush, 32'd3, "p3");
    model(OpPop, 32'd0, "pop ignore", e);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = OpPop;
    @(posedge clk);
    @(negedge clk);
    check("busy ready", 64'(ready), 64'd0);
    cmd_op = OpPush; in_num = 32'd99;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_op = OpNop;
    check("pop ignore ready", 64'(ready), 64'd1);
    check_state(e);
    @(negedge clk);
    e.tag = "no queued push";
    check_state(e);

    // Reset asserted while the POP is in its read cycle.
    issue(OpPush, 32'd3, "p3b");
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = OpPop;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0; cmd_op = OpNop;
    check("pre-abort ready", 64'(ready), 64'd0);
    reset = 1'b0;
    stk.delete(); m_err = 1'b0; m_hwm = 0;
    #1;
    check("abort ready", 64'(ready), 64'd1);
    e.tag = "abort"; e.sz = 0; e.tp = 0; e.err = 0; e.hw = 0;
    check_state(e);
    @(negedge clk);
    reset = 1'b1;
    issue(OpPush, 32'd6, "push after abort");
    issue(OpPush, 32'd8, "push8");
    issue(OpSwap, 32'd0, "swap2");
    issue(OpPop, 32'd0, "pop->8");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/calc_stack_gen.md
Name: calc_stack_gen

Overview:
Parametrised successor to the calculator's operand stack, with configurable data width and depth.
- Top of stack (TOS) lives in a register; entries below TOS live in an inferred single-port synchronous-read RAM.
- Push, replace, dup and clear complete in 1 cycle. Pop and swap take 2 cycles.
- Adds swap, dup, clear, full/empty flags and an opcode/valid/ready handshake toward the calculator control FSM.

Parameters:
WIDTH, 32, data word width in bits.
DEPTH, 512, maximum number of stack entries (TOS plus DEPTH-1 RAM words); legal range >= 2.
AW, $clog2(DEPTH), RAM address width (derived; do not override).

Ports:
clk  in  1  clock; all state updates on rising edge.
reset  in  1  asynchronous, active-low reset.
cmd_valid  in  1  command strobe; accepted only while ready=1.
cmd_op  in  3  opcode: 0 NOP, 1 PUSH, 2 POP, 3 REPLACE, 4 SWAP, 5 DUP, 6 CLEAR, 7 reserved (treated as NOP).
in_num  in  WIDTH  operand for PUSH and REPLACE.
ready  out  1  high when in IDLE; a command is accepted on cycles where cmd_valid & ready.
size  out  AW+1  current entry count, 0..DEPTH.
top  out  WIDTH  TOS value; 0 when size=0.
error  out  1  result of the last accepted non-NOP command.
empty  out  1  size==0 (combinational).
full  out  1  size==DEPTH (combinational).

Behaviour:
- Reset (reset low, asynchronous): size=0, top=0, error=0, state=IDLE, RAM write enable low. RAM contents are not cleared.
- Reset asserted mid-operation aborts any POP or SWAP in flight. Stack then reads empty.
- Storage: element i (bottom=0) is in mem[i] for i<size-1. Element size-1 is in `top`.
- States:
  - IDLE: ready=1.
  - RD: ready=0; RAM data is valid this cycle.
- Commands are sampled in IDLE only. cmd_valid while ready=0 is ignored; it is not an error and not queued.
- Error rule:
  - Failed command: error<=1; size, top and memory unchanged.
  - Successful command: error<=0.
  - NOP and reserved opcodes leave error unchanged.
- PUSH:
  - full: error.
  - size==0: top<=in_num, size<=1.
  - else: mem[size-1]<=top, top<=in_num, size<=size+1.
  - Stays in IDLE.
- REPLACE:
  - empty: error.
  - else: top<=in_num. No RAM access; stays in IDLE.
- DUP:
  - empty or full: error.
  - else: mem[size-1]<=top, size<=size+1; top unchanged. Stays in IDLE.
- CLEAR: size<=0, top<=0, error<=0. Stays in IDLE.
- POP:
  - empty: error.
  - size==1: top<=0, size<=0. Stays in IDLE.
  - else: read address size-2, size<=size-1, go to RD. In RD: top<=RAM data, go to IDLE.
- SWAP:
  - size<2: error.
  - else: read address size-2, go to RD, remembering the op as swap. In RD: top<=RAM data, and on the same cycle write the old top to mem[size-2]. The RAM is read-before-write, so the read data is unaffected. Go to IDLE.
- Latency, from acceptance edge to ready high again: 1 cycle for PUSH, REPLACE, DUP, CLEAR and errored ops; 2 cycles for POP and SWAP.
- size arithmetic: AW+1 bits, never wraps. Overflow and underflow are prevented by the error rule.
- The RAM is written at most once per cycle and is never read and written to different addresses in the same cycle.

Optional Feature:
Macro CALC_STACK_HWM_EN.
- Defined: extra output `hwm` (AW+1 bits), the high-water mark of size since reset.
  - Reset to 0.
  - Updated to the new size on the cycle size exceeds it.
  - Not cleared by CLEAR.
- Undefined: port absent, no logic.

Test Plan:
- Reset, then PUSH 5, PUSH 7 -> size=2, top=7. POP -> ready low 1 cycle, then top=5, size=1, error=0.
- From empty, POP -> error=1, size=0, top=0. Then PUSH 3 -> error=0, top=3.
- PUSH 1, PUSH 2, SWAP -> top=1 after 2 cycles. Then POP -> top=2, size=1.
- DEPTH=4: PUSH 10,20,30,40 -> full=1. PUSH 50 -> error=1, top=40. DUP -> error=1. Pop four times -> tops 30,20,10,0, empty=1.
- PUSH 9, DUP, REPLACE 4 -> top=4, size=2. POP -> top=9. CLEAR -> size=0, top=0. With CALC_STACK_HWM_EN, hwm=2.
- Issue POP (size=3); assert reset during RD -> immediately size=0, top=0, ready=1. Assert cmd_valid with PUSH while ready=0 -> command ignored.
